// File: rtl/l2_line_fill_pkg.sv
// rtl/l2_line_fill_pkg.sv - shared cache geometry and fill FSM encoding
package l2_line_fill_pkg;

  localparam int data_width    = 32;
  localparam int address_width = 32;
  localparam int block_size    = 32;

  // The L1 derives its tag/offset split from these same values.
  localparam int offset_width = $clog2(data_width * block_size / 8);
  localparam int line_width   = address_width - offset_width;
  localparam int cache_width  = block_size * data_width;
  localparam int idx_width    = $clog2(block_size);
  localparam int cnt_width    = idx_width + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/l2_line_fill_if.sv
// rtl/l2_line_fill_if.sv - L1 miss port and memory read bus seen by the fill engine
interface l2_line_fill_if;
  import l2_line_fill_pkg::*;

  logic [line_width-1:0]    ADDR_FROM_L1;
  logic                     ADDR_FROM_L1_VALID;
  logic [cache_width-1:0]   DATA_TO_L1;
  logic                     DATA_TO_L1_VALID;
  logic                     BUSY;
  logic [address_width-1:0] MEM_ADDR;
  logic                     MEM_RD_VALID;
  logic                     MEM_RD_READY;
  logic [data_width-1:0]    MEM_RDATA;
  logic                     MEM_RDATA_VALID;

  modport master (
    input  ADDR_FROM_L1, ADDR_FROM_L1_VALID, MEM_RD_READY, MEM_RDATA, MEM_RDATA_VALID,
    output DATA_TO_L1, DATA_TO_L1_VALID, BUSY, MEM_ADDR, MEM_RD_VALID
  );

  modport slave (
    output ADDR_FROM_L1, ADDR_FROM_L1_VALID, MEM_RD_READY, MEM_RDATA, MEM_RDATA_VALID,
    input  DATA_TO_L1, DATA_TO_L1_VALID, BUSY, MEM_ADDR, MEM_RD_VALID
  );

endinterface

// File: rtl/l2_line_fill_line_assembler.sv
// rtl/l2_line_fill_line_assembler.sv - cache line slot register with indexed word write
module l2_line_fill_line_assembler
  import l2_line_fill_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [idx_width-1:0]   wr_idx,
  input  logic [data_width-1:0]  wr_data,
  output logic [cache_width-1:0] line
);

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (wr_en) begin
      line[wr_idx*data_width +: data_width] <= wr_data;
    end
  end

endmodule

// File: rtl/l2_line_fill.sv
// rtl/l2_line_fill.sv - fetches one cache line as sequential word reads with bounded outstanding requests
module l2_line_fill
  import l2_line_fill_pkg::*;
#(
  parameter int max_outstanding = 4
) (
  input logic           CLK,
  input logic           RST,
  l2_line_fill_if.master bus
);

  fill_state_t            state, state_n;
  logic [line_width-1:0]  line_addr, pend_addr, start_addr;
  logic                   pend_valid, overflow, start;
  logic [cnt_width-1:0]   issue_cnt, recv_cnt, outstanding;
  logic                   issue_fire, rx_fire, last_word;
  logic [cache_width-1:0] line_data;

  // Issue gating only looks at registered counters, so VALID cannot drop
  // while stalled: issue_cnt is frozen and outstanding can only shrink.
  assign outstanding      = issue_cnt - recv_cnt;
  assign bus.MEM_RD_VALID = (state == FETCH)
                          && (issue_cnt < cnt_width'(block_size))
                          && (outstanding < cnt_width'(max_outstanding));
  assign bus.MEM_ADDR     = {line_addr, {offset_width{1'b0}}}
                          + address_width'(issue_cnt) * address_width'(data_width / 8);

  assign issue_fire = bus.MEM_RD_VALID && bus.MEM_RD_READY;
  assign rx_fire    = (state == FETCH) && bus.MEM_RDATA_VALID && (recv_cnt != issue_cnt);
  assign last_word  = rx_fire && (recv_cnt == cnt_width'(block_size - 1));

  assign bus.DATA_TO_L1_VALID = (state == RESP);
  assign bus.BUSY             = (state != IDLE);
  assign bus.DATA_TO_L1       = line_data;

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    start_addr = bus.ADDR_FROM_L1;
    case (state)
      IDLE: begin
        if (bus.ADDR_FROM_L1_VALID) begin
          state_n = FETCH;
          start   = 1'b1;
        end
      end
      FETCH: begin
        if (last_word) state_n = RESP;
      end
      RESP: begin
        if (pend_valid) begin
          state_n    = FETCH;
          start      = 1'b1;
          start_addr = pend_addr;
        end else if (bus.ADDR_FROM_L1_VALID) begin
          state_n = FETCH;
          start   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      line_addr  <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start) begin
        line_addr <= start_addr;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (issue_fire) issue_cnt <= issue_cnt + cnt_width'(1);
        if (rx_fire)    recv_cnt  <= recv_cnt + cnt_width'(1);
      end

      // In RESP the pending slot is consumed; a same-cycle request refills it.
      if (bus.ADDR_FROM_L1_VALID && state == FETCH) begin
        if (pend_valid) begin
          overflow <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= bus.ADDR_FROM_L1;
        end
      end else if (state == RESP && pend_valid) begin
        pend_valid <= bus.ADDR_FROM_L1_VALID;
        pend_addr  <= bus.ADDR_FROM_L1;
      end
    end
  end

  l2_line_fill_line_assembler u_assembler (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (rx_fire),
    .wr_idx  (recv_cnt[idx_width-1:0]),
    .wr_data (bus.MEM_RDATA),
    .line    (line_data)
  );

endmodule

// File: tb/tb_l2_line_fill.sv
// tb/tb_l2_line_fill.sv - directed and randomized fills checked against an in-order memory model
module tb_l2_line_fill;
  import l2_line_fill_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_line_fill_if bus();

  l2_line_fill #(.max_outstanding(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: in-order responses exactly lat cycles after acceptance.
  int          lat      = 2;
  int          rdy_mode = 0;
  logic [31:0] mem_seed = 32'hA000_0000;
  logic [31:0] mem_ref  = 32'h0000_2000;
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          phase = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return mem_seed + ((a - mem_ref) >> 2);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      bus.MEM_RDATA_VALID <= 1'b0;
      bus.MEM_RDATA       <= '0;
      bus.MEM_RD_READY    <= 1'b0;
      phase = 0;
    end else begin
      if (bus.MEM_RD_VALID && bus.MEM_RD_READY) begin
        q_addr.push_back(bus.MEM_ADDR);
        q_due.push_back(cyc + lat);
      end
      if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
        bus.MEM_RDATA       <= mem_fn(q_addr[0]);
        bus.MEM_RDATA_VALID <= 1'b1;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        bus.MEM_RDATA       <= $urandom;
        bus.MEM_RDATA_VALID <= 1'b0;
      end
      case (rdy_mode)
        0:       bus.MEM_RD_READY <= 1'b1;
        1:       bus.MEM_RD_READY <= (phase == 0);
        default: bus.MEM_RD_READY <= 1'($urandom_range(0, 1));
      endcase
      phase = (phase == 2) ? 0 : phase + 1;
    end
  end

  // Bus observer: issue order, stall stability, outstanding count, delivered lines.
  int                     out_m = 0, max_out = 0, stab_bad = 0, out_bad = 0, rx_cnt = 0;
  logic                   prev_stall = 1'b0;
  logic [31:0]            prev_addr;
  logic [31:0]            fire_addr[$];
  int                     fire_cyc[$];
  logic [cache_width-1:0] lines[$];
  int                     pulse_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      out_m      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(bus.MEM_RD_VALID && bus.MEM_ADDR == prev_addr)) stab_bad++;
      if (bus.MEM_RD_VALID && out_m >= 4) out_bad++;
      if (out_m > max_out) max_out = out_m;
      prev_stall = bus.MEM_RD_VALID && !bus.MEM_RD_READY;
      prev_addr  = bus.MEM_ADDR;
      if (bus.MEM_RD_VALID && bus.MEM_RD_READY) begin
        fire_addr.push_back(bus.MEM_ADDR);
        fire_cyc.push_back(cyc);
        out_m++;
      end
      if (bus.MEM_RDATA_VALID) begin
        rx_cnt++;
        out_m--;
      end
      if (bus.DATA_TO_L1_VALID) begin
        lines.push_back(bus.DATA_TO_L1);
        pulse_cyc.push_back(cyc);
      end
    end
  end

  int idx_line = 0;
  int idx_fire = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [line_width-1:0] la, output int t);
    bus.ADDR_FROM_L1       = la;
    bus.ADDR_FROM_L1_VALID = 1'b1;
    t = cyc;
    tick();
    bus.ADDR_FROM_L1_VALID = 1'b0;
  endtask

  task automatic wait_lines(input string tag, input int n);
    int budget;
    budget = 3000;
    while (lines.size() < idx_line + n && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_done"}, 64'(lines.size() >= idx_line + n), 64'd1);
  endtask

  task automatic check_fill(input string tag, input logic [line_width-1:0] la);
    logic [31:0]            base, exp_w, got_w, bad_got, bad_exp, got_a, bad_a;
    logic [cache_width-1:0] got;
    int                     nbad_w, nbad_a;
    base   = {la, {offset_width{1'b0}}};
    got    = (idx_line < lines.size()) ? lines[idx_line] : '0;
    nbad_w = 0;
    nbad_a = 0;
    bad_got = '0; bad_exp = '0; bad_a = '0;
    for (int k = 0; k < block_size; k++) begin
      exp_w = mem_fn(base + 32'(4 * k));
      got_w = got[k*data_width +: data_width];
      if (got_w !== exp_w) begin
        if (nbad_w == 0) begin bad_got = got_w; bad_exp = exp_w; end
        nbad_w++;
      end
      got_a = (idx_fire + k < fire_addr.size()) ? fire_addr[idx_fire + k] : 32'hxxxx_xxxx;
      if (got_a !== base + 32'(4 * k)) begin
        if (nbad_a == 0) bad_a = got_a;
        nbad_a++;
      end
    end
    checks++;
    assert (nbad_w == 0) else begin
      errors++;
      $error("FAIL %s_line: %0d bad words, first observed=%h expected=%h", tag, nbad_w, bad_got, bad_exp);
    end
    checks++;
    assert (nbad_a == 0) else begin
      errors++;
      $error("FAIL %s_addr: %0d bad read addresses, first observed=%h base=%h", tag, nbad_a, bad_a, base);
    end
    idx_line++;
    idx_fire += block_size;
  endtask

  initial begin
    int                    t, t2, nl, budget, rx0;
    logic [line_width-1:0] la, lb, lc;

    rst = 1'b1;
    bus.ADDR_FROM_L1       = '0;
    bus.ADDR_FROM_L1_VALID = 1'b0;
    tick();
    tick();
    // A request coinciding with reset must be ignored.
    bus.ADDR_FROM_L1       = '1;
    bus.ADDR_FROM_L1_VALID = 1'b1;
    tick();
    bus.ADDR_FROM_L1_VALID = 1'b0;
    check("rst_valid", 64'(bus.DATA_TO_L1_VALID), 64'd0);
    check("rst_rdvalid", 64'(bus.MEM_RD_VALID), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_data", 64'(|bus.DATA_TO_L1), 64'd0);
    check("rst_addr", 64'(bus.MEM_ADDR), 64'd0);
    check("rst_overflow", 64'(dut.overflow), 64'd0);
    check("rst_pending", 64'(dut.pend_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("req_in_rst_ignored", 64'(bus.BUSY), 64'd0);

    // Single fill, READY=1, latency 2, line 0x40.
    lat = 2; rdy_mode = 0; mem_seed = 32'hA000_0000; mem_ref = 32'h0000_2000;
    do_req(25'h40, t);
    check("t1_busy", 64'(bus.BUSY), 64'd1);
    check("t1_rdvalid", 64'(bus.MEM_RD_VALID), 64'd1);
    check("t1_first_addr", 64'(bus.MEM_ADDR), 64'h2000);
    wait_lines("t1", 1);
    check("t1_pulse_cycle", 64'(pulse_cyc[idx_line]), 64'(t + block_size + lat + 1));
    tick();
    check("t1_busy_after", 64'(bus.BUSY), 64'd0);
    check_fill("t1", 25'h40);
    repeat (40) tick();
    check("t1_single_pulse", 64'(lines.size()), 64'(idx_line));

    // Backpressure: READY 1,0,0 repeating.
    lat = $urandom_range(1, 6); rdy_mode = 1; mem_seed = $urandom; mem_ref = $urandom;
    do_req(25'h40, t);
    wait_lines("t2", 1);
    check_fill("t2", 25'h40);
    check("t2_addr_stable", 64'(stab_bad), 64'd0);
    check("t2_outstanding_gate", 64'(out_bad), 64'd0);
    check("t2_max_outstanding", 64'(max_out <= 4), 64'd1);

    // Back-to-back: second request parks in the pending slot.
    lat = 2; rdy_mode = 0; mem_seed = $urandom; mem_ref = 32'h0000_2000;
    do_req(25'h40, t);
    repeat (5) tick();
    do_req(25'h41, t2);
    check("t3_pending", 64'(dut.pend_valid), 64'd1);
    wait_lines("t3", 2);
    check("t3_restart_cycle", 64'(fire_cyc[idx_fire + block_size]), 64'(pulse_cyc[idx_line] + 1));
    check_fill("t3a", 25'h40);
    check_fill("t3b", 25'h41);
    check("t3_overflow", 64'(dut.overflow), 64'd0);

    // Third request while pending is full is dropped.
    lat = $urandom_range(1, 6); rdy_mode = 2; mem_seed = $urandom; mem_ref = $urandom;
    la = 25'($urandom); lb = 25'($urandom); lc = 25'($urandom);
    do_req(la, t);
    repeat (3) tick();
    do_req(lb, t);
    repeat (3) tick();
    do_req(lc, t);
    check("t4_overflow", 64'(dut.overflow), 64'd1);
    wait_lines("t4", 2);
    repeat (300) tick();
    check("t4_two_fills", 64'(lines.size()), 64'(idx_line + 2));
    check("t4_idle", 64'(bus.BUSY), 64'd0);
    check_fill("t4a", la);
    check_fill("t4b", lb);

    // Reset after ten words received.
    lat = 2; rdy_mode = 0; mem_seed = $urandom; mem_ref = $urandom;
    rx0 = rx_cnt;
    do_req(25'($urandom), t);
    budget = 200;
    while (rx_cnt < rx0 + 10 && budget > 0) begin
      tick();
      budget--;
    end
    check("t5_ten_words", 64'(rx_cnt >= rx0 + 10), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 64'(bus.BUSY), 64'd0);
    check("t5_rdvalid", 64'(bus.MEM_RD_VALID), 64'd0);
    check("t5_state", 64'(dut.state), 64'(IDLE));
    check("t5_overflow_clr", 64'(dut.overflow), 64'd0);
    check("t5_data_clr", 64'(|bus.DATA_TO_L1), 64'd0);
    nl = lines.size();
    repeat (60) tick();
    check("t5_no_pulse", 64'(lines.size()), 64'(nl));
    idx_line = lines.size();
    idx_fire = fire_addr.size();
    la = 25'($urandom);
    do_req(la, t);
    wait_lines("t5", 1);
    check_fill("t5", la);

    // Wrap-around at the top of the address space.
    lat = 3; rdy_mode = 1; mem_seed = $urandom; mem_ref = 32'hFFFF_FF80;
    do_req('1, t);
    check("t6_first_addr", 64'(bus.MEM_ADDR), 64'hFFFF_FF80);
    wait_lines("t6", 1);
    check("t6_last_addr", 64'(fire_addr[idx_fire + block_size - 1]), 64'hFFFF_FFFC);
    check_fill("t6", '1);

    // Randomized single fills.
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 6); rdy_mode = $urandom_range(0, 2);
      mem_seed = $urandom; mem_ref = $urandom;
      la = 25'($urandom);
      do_req(la, t);
      wait_lines("rnd", 1);
      check_fill("rnd", la);
    end

    check("end_addr_stable", 64'(stab_bad), 64'd0);
    check("end_outstanding_gate", 64'(out_bad), 64'd0);
    check("end_max_outstanding", 64'(max_out <= 4), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_line_fill.md
# l2_line_fill

Line-fill engine sitting directly downstream of the L1 data cache miss port. It accepts a line address on the cache's L2 request interface and fetches the line as `block_size` sequential word reads over a word-wide memory read bus, with up to `max_outstanding` reads in flight. It assembles the returned words into one cache line and returns it with a single-cycle valid pulse in the format the cache writes directly into its data array.

## Interface
- `data_width`, 32, word width on the memory bus and within a line.
- `address_width`, 32, byte address width.
- `block_size`, 32, words per cache line.
- `max_outstanding`, 4, maximum issued-but-unreturned memory reads; range 1..block_size.
- `offset_width`, localparam, `$clog2(data_width*block_size/8)`; 7 with the defaults.
- `cache_width`, localparam, `block_size*data_width`.
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ADDR_FROM_L1`  in  address_width-offset_width  line address of the miss.
- `ADDR_FROM_L1_VALID`  in  1  single-cycle request pulse.
- `DATA_TO_L1`  out  cache_width  assembled line; word k occupies bits [k*data_width +: data_width].
- `DATA_TO_L1_VALID`  out  1  one-cycle pulse; line is valid in that cycle.
- `BUSY`  out  1  high from request capture until the `DATA_TO_L1_VALID` cycle, inclusive.
- `MEM_ADDR`  out  address_width  byte address of the current read request.
- `MEM_RD_VALID`  out  1  read request valid.
- `MEM_RD_READY`  in  1  memory accepts the request when VALID&READY.
- `MEM_RDATA`  in  data_width  read data; responses return in request order.
- `MEM_RDATA_VALID`  in  1  one word returned.

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE: on `ADDR_FROM_L1_VALID`, latch the line address, clear the issue and receive counters, and go to FETCH.
- Request latch: a request arriving while not IDLE goes into a one-deep pending register. A further request while pending is full is dropped and sets sticky `overflow` (internal, reset-cleared, visible to the bench).
- FETCH issue side: `MEM_RD_VALID` is high while issue_cnt < block_size and outstanding < `max_outstanding`.
  - outstanding = issue_cnt − recv_cnt, computed from registered counters.
  - `MEM_ADDR = {line_addr, offset_width'b0} + issue_cnt*(data_width/8)`.
  - issue_cnt increments on VALID&READY.
  - Once `MEM_RD_VALID` is asserted, it and `MEM_ADDR` stay stable until READY.
- FETCH receive side: on `MEM_RDATA_VALID`, write `MEM_RDATA` into line slot recv_cnt and increment recv_cnt. Unexpected data with recv_cnt == issue_cnt is ignored.
- Issue and receive in the same cycle are both applied.
- When the last word is received (recv_cnt reaching block_size), go to RESP.
- RESP: one cycle with `DATA_TO_L1_VALID` = 1.
  - Next state is FETCH on the pending address, or on a request arriving this same cycle, with counters cleared.
  - Otherwise next state is IDLE.
- `DATA_TO_L1` holds its value until slots are overwritten by the next fill. The L1 samples it only in the valid cycle.
- Counters are $clog2(block_size)+1 bits wide. Address arithmetic wraps modulo 2^address_width.

## Timing
- Reset values:
  - `DATA_TO_L1_VALID`, `MEM_RD_VALID`, `BUSY` = 0.
  - `DATA_TO_L1` = 0, `MEM_ADDR` = 0.
  - State IDLE, pending empty, overflow = 0.
- Request pulse in cycle t → `BUSY` and `MEM_RD_VALID` high from t+1. The first `MEM_ADDR` is the line base.
- With READY held high, memory latency L, and max_outstanding ≥ L+1: one issue per cycle. The last word arrives at t+block_size+L and `DATA_TO_L1_VALID` fires the cycle after.
- `RST` mid-burst: the next cycle returns to IDLE, counters are cleared, and pending and the line buffer are discarded. The memory shares `RST`, so no stale responses follow.
- A request pulse in the same cycle as `RST` is ignored.

## Structure
- Shared cache package holds:
  - `data_width`, `address_width`, `block_size`;
  - derived `offset_width`, `line_width`, `cache_width`;
  - FSM state encoding.
  
  The L1 cache and this block must derive line/offset splits identically from it.
- One sub-module is natural: `line_assembler`, the block_size×data_width slot register with indexed word write. The FSM, counters and pending latch stay in the top level.

## Test plan
- Single fill, defaults, READY=1, latency 2, line addr 0x40:
  - reads 0x2000..0x207C in order, one per cycle;
  - memory returns 0xA000_0000+k;
  - one valid pulse, slot k = 0xA000_0000+k.
- Backpressure: READY toggles 1,0,0,1…:
  - `MEM_ADDR` is stable while VALID&!READY;
  - no more than 4 outstanding reads;
  - the line is correct.
- Back-to-back requests: line 0x40, then line 0x41 mid-fetch:
  - second request is pending;
  - fetch from 0x2080 starts the cycle after the first valid pulse;
  - both lines correct; overflow = 0.
- Third request while pending is full → dropped, overflow = 1, two fills complete.
- `RST` asserted after 10 words received → next cycle IDLE, `BUSY` = 0, no valid pulse. A fresh request completes normally.
- Wrap-around: line addr all-ones → addresses 0xFFFF_FF80..0xFFFF_FFFC, no overflow into other bits.
